// File: rtl/bin_to_bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter:
// FSM state encodings, iteration bound and saturation code.
package bin_to_bcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] ITER_LAST = 3'd7;
    localparam logic [7:0] BCD_SAT   = 8'h99;

    localparam int SCRATCH_W = 20;

endpackage

// File: rtl/bcd_nibble_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD nibble of 5..9 so the
// following left shift carries correctly into the next decimal digit.
module bcd_nibble_adjust (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one 8-bit value per start request,
// eight shift iterations, result registered and held until the next conversion.
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter bit SAT_ON_OVF = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] binIn,
    output logic       busy,
    output logic       done,
    output logic [7:0] bcdOut,
    output logic [1:0] hundreds,
    output logic       overflow
);

    logic [1:0]           state_q, state_d;
    logic [2:0]           iter_q, iter_d;
    logic [SCRATCH_W-1:0] scratch_q, scratch_d;
    logic [7:0]           bcd_q, bcd_d;
    logic [1:0]           hund_q, hund_d;
    logic                 ovf_q, ovf_d;

    logic [3:0]           adj_ones, adj_tens, adj_hund;
    logic [SCRATCH_W-1:0] adj_word, shift_word;
    logic                 last_ovf;

    bcd_nibble_adjust u_adj_ones (.nib_in(scratch_q[11:8]),  .nib_out(adj_ones));
    bcd_nibble_adjust u_adj_tens (.nib_in(scratch_q[15:12]), .nib_out(adj_tens));
    bcd_nibble_adjust u_adj_hund (.nib_in(scratch_q[19:16]), .nib_out(adj_hund));

    assign adj_word   = {adj_hund, adj_tens, adj_ones, scratch_q[7:0]};
    assign shift_word = adj_word << 1;
    assign last_ovf   = (shift_word[19:16] != 4'd0);

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        hund_d    = hund_q;
        ovf_d     = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    scratch_d = {12'h000, binIn};
                    iter_d    = 3'd0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = shift_word;
                iter_d    = iter_q + 3'd1;
                // Outputs load from the final shifted word on the edge that enters DONE.
                if (iter_q == ITER_LAST) begin
                    state_d = ST_DONE;
                    hund_d  = shift_word[17:16];
                    ovf_d   = last_ovf;
                    bcd_d   = (SAT_ON_OVF && last_ovf) ? BCD_SAT : shift_word[15:8];
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            iter_q    <= 3'd0;
            scratch_q <= '0;
            bcd_q     <= 8'h00;
            hund_q    <= 2'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            hund_q    <= hund_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);
    assign bcdOut   = bcd_q;
    assign hundreds = hund_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a saturating and a non-saturating
// instance share stimulus and are compared against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] binIn;

    logic       s_busy, s_done, s_ovf;
    logic [7:0] s_bcd;
    logic [1:0] s_hund;
    logic       r_busy, r_done, r_ovf;
    logic [7:0] r_bcd;
    logic [1:0] r_hund;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.SAT_ON_OVF(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .binIn(binIn),
        .busy(s_busy), .done(s_done), .bcdOut(s_bcd), .hundreds(s_hund), .overflow(s_ovf)
    );

    bin_to_bcd_seq #(.SAT_ON_OVF(1'b0)) dut_raw (
        .clk(clk), .reset(reset), .start(start), .binIn(binIn),
        .busy(r_busy), .done(r_done), .bcdOut(r_bcd), .hundreds(r_hund), .overflow(r_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] value;
        logic [7:0] bcd_sat;
        logic [7:0] bcd_raw;
        logic [1:0] hund;
        logic       ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain decimal arithmetic on the operand.
    function automatic logic [7:0] model_bcd(input int v, input bit sat);
        if (sat && v > 99) return 8'h99;
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic check_idle_outputs_zero(input string tag);
        check({tag, "_sbcd"},  32'(s_bcd),  32'h00);
        check({tag, "_shund"}, 32'(s_hund), 32'h0);
        check({tag, "_sovf"},  32'(s_ovf),  32'h0);
        check({tag, "_sbusy"}, 32'(s_busy), 32'h0);
        check({tag, "_sdone"}, 32'(s_done), 32'h0);
        check({tag, "_rbcd"},  32'(r_bcd),  32'h00);
    endtask

    // One full conversion: checks latency, busy length, outputs, pulse width, hold.
    task automatic run_conv(input logic [7:0] v, input logic [7:0] exp_sat,
                            input logic [7:0] exp_raw, input logic [1:0] exp_hund,
                            input logic exp_ovf, input string tag);
        int lat, busy_cnt;
        @(negedge clk);
        start = 1'b1;
        binIn = v;
        @(negedge clk);
        start = 1'b0;
        binIn = 8'($urandom);
        lat = 1;
        busy_cnt = 0;
        while (!s_done && lat < 30) begin
            if (s_busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_busy_len"}, 32'(busy_cnt), 32'd8);
        check({tag, "_busy_at_done"}, 32'(s_busy), 32'd0);
        check({tag, "_raw_done"}, 32'(r_done), 32'd1);
        check({tag, "_bcd_sat"}, 32'(s_bcd), 32'(exp_sat));
        check({tag, "_bcd_raw"}, 32'(r_bcd), 32'(exp_raw));
        check({tag, "_hund"}, 32'(s_hund), 32'(exp_hund));
        check({tag, "_ovf"}, 32'(s_ovf), 32'(exp_ovf));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(s_done), 32'd0);
        binIn = 8'($urandom);
        repeat (3) @(negedge clk);
        check({tag, "_hold"}, 32'(s_bcd), 32'(exp_sat));
    endtask

    vec_t vecs[9];

    initial begin
        int v, dcount;
        logic [7:0] mb;

        vecs[0] = '{8'd0,   8'h00, 8'h00, 2'd0, 1'b0};
        vecs[1] = '{8'd42,  8'h42, 8'h42, 2'd0, 1'b0};
        vecs[2] = '{8'd99,  8'h99, 8'h99, 2'd0, 1'b0};
        vecs[3] = '{8'd100, 8'h99, 8'h00, 2'd1, 1'b1};
        vecs[4] = '{8'd255, 8'h99, 8'h55, 2'd2, 1'b1};
        vecs[5] = '{8'd5,   8'h05, 8'h05, 2'd0, 1'b0};
        vecs[6] = '{8'd10,  8'h10, 8'h10, 2'd0, 1'b0};
        vecs[7] = '{8'd199, 8'h99, 8'h99, 2'd1, 1'b1};
        vecs[8] = '{8'd200, 8'h99, 8'h00, 2'd2, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        binIn = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_idle_outputs_zero("reset");

        for (int i = 0; i < 9; i++)
            run_conv(vecs[i].value, vecs[i].bcd_sat, vecs[i].bcd_raw,
                     vecs[i].hund, vecs[i].ovf, $sformatf("vec%0d", i));

        // Second start during SHIFT is ignored.
        @(negedge clk);
        start = 1'b1;
        binIn = 8'd17;
        @(negedge clk);
        start = 1'b0;
        binIn = 8'd0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        binIn = 8'd88;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        for (int i = 0; i < 25; i++) begin
            if (s_done) begin
                dcount++;
                check("ignore_bcd", 32'(s_bcd), 32'h17);
            end
            @(negedge clk);
        end
        check("ignore_done_count", 32'(dcount), 32'd1);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clk);
        start = 1'b1;
        binIn = 8'd63;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs_zero("abort");
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            if (s_done) dcount++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        run_conv(8'd5, 8'h05, 8'h05, 2'd0, 1'b0, "after_abort");

        // Reset wins over start in the same cycle.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        binIn = 8'd77;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_prio_busy", 32'(s_busy), 32'd0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            if (s_done) dcount++;
            @(negedge clk);
        end
        check("rst_prio_no_done", 32'(dcount), 32'd0);

        // Random operands against the decimal model.
        for (int i = 0; i < 30; i++) begin
            v = int'($urandom_range(0, 255));
            mb = model_bcd(v, 1'b1);
            run_conv(8'(v), mb, model_bcd(v, 1'b0), 2'(v / 100), (v > 99),
                     $sformatf("rnd%0d_v%0d", i, v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
